// File: rtl/clk_gen_downsampler.sv
// Glitch-free programmable divider for the ring-oscillator clock: period = 2*(ratio+1) cycles.
// Ratio changes are staged and only take effect on a full-period boundary (low phase end).
module clk_gen_downsampler #(
    parameter int          WIDTH       = 8,
    parameter int unsigned RESET_RATIO = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             cfg_valid_i,
    input  logic [WIDTH-1:0] cfg_ratio_i,
    output logic             cfg_ready_o,
    output logic             clk_r_o,
    output logic             tick_o,
    output logic [WIDTH-1:0] ratio_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic             at_top;
    logic             xfer;

    assign cfg_ready_o = !reset_i && (state != PEND);
    assign xfer        = cfg_valid_i && cfg_ready_o;
    assign at_top      = (cnt == ratio_o);
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            clk_r_o <= 1'b0;
            tick_o  <= 1'b0;
            ratio_o <= WIDTH'(RESET_RATIO);
        end else begin
            tick_o <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    clk_r_o <= 1'b0;
                    if (xfer)
                        ratio_o <= cfg_ratio_i;
                    if (en_i) begin
                        state   <= RUN;
                        clk_r_o <= 1'b1;
                        tick_o  <= 1'b1;
                    end
                end
                RUN, PEND: begin
                    cnt <= cnt + 1'b1;
                    // An offer in the boundary cycle still only goes pending, never shortening this period
                    if (state == RUN && xfer) begin
                        pend  <= cfg_ratio_i;
                        state <= PEND;
                    end
                    if (at_top) begin
                        cnt <= '0;
                        if (clk_r_o) begin
                            clk_r_o <= 1'b0;
                        end else begin
                            if (state == PEND)
                                ratio_o <= pend;
                            if (en_i) begin
                                clk_r_o <= 1'b1;
                                tick_o  <= 1'b1;
                                if (state == PEND)
                                    state <= RUN;
                            end else begin
                                // Stopping: a ratio offered right now commits with the stop
                                state <= IDLE;
                                if (state == RUN && xfer)
                                    ratio_o <= cfg_ratio_i;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen_downsampler.sv
// Directed bench for clk_gen_downsampler: hand-computed clk_r/tick waveforms per cycle.
module tb_clk_gen_downsampler;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       en_i = 1'b0;
    logic       cfg_valid_i = 1'b0;
    logic [7:0] cfg_ratio_i = '0;
    logic       cfg_ready_o;
    logic       clk_r_o;
    logic       tick_o;
    logic [7:0] ratio_o;
    logic       busy_o;

    int n_chk = 0;
    int n_pass = 0;

    clk_gen_downsampler #(.WIDTH(8), .RESET_RATIO(0)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .en_i        (en_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ratio_i (cfg_ratio_i),
        .cfg_ready_o (cfg_ready_o),
        .clk_r_o     (clk_r_o),
        .tick_o      (tick_o),
        .ratio_o     (ratio_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // bit i of the patterns is the expected value after the (i+1)-th clock edge
    task automatic chk_seq(input string tag, input int n, input logic [31:0] clk_bits,
                           input logic [31:0] tick_bits);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk($sformatf("%s_clk%0d", tag, i), 32'(clk_r_o), 32'(clk_bits[i]));
            chk($sformatf("%s_tick%0d", tag, i), 32'(tick_o), 32'(tick_bits[i]));
        end
    endtask

    initial begin
        int ticks, first_tick, second_tick, highs;
        // reset state
        cyc(); cyc();
        chk("rst_clk", 32'(clk_r_o), 0);
        chk("rst_tick", 32'(tick_o), 0);
        chk("rst_ratio", 32'(ratio_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ready", 32'(cfg_ready_o), 0);
        reset_i = 1'b0;
        cyc();
        chk("idle_ready", 32'(cfg_ready_o), 1);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_clk", 32'(clk_r_o), 0);

        // default ratio 0: divide-by-2, then disable in high phase
        en_i = 1'b1;
        chk_seq("r0", 5, 32'b10101, 32'b10101);
        chk("r0_busy", 32'(busy_o), 1);
        en_i = 1'b0;
        chk_seq("r0off", 3, 32'b000, 32'b000);
        chk("r0off_busy", 32'(busy_o), 0);

        // configure R=3 in IDLE, applied immediately
        cfg_valid_i = 1'b1; cfg_ratio_i = 8'd3;
        cyc();
        cfg_valid_i = 1'b0;
        chk("cfg3_ratio", 32'(ratio_o), 3);
        chk("cfg3_busy", 32'(busy_o), 0);
        en_i = 1'b1;
        chk_seq("r3", 9, 32'b1_0000_1111, 32'b1_0000_0001);

        // change to R=1 mid high phase
        cyc();
        chk("chg_clk10", 32'(clk_r_o), 1);
        cfg_valid_i = 1'b1; cfg_ratio_i = 8'd1;
        chk("chg_ready_pre", 32'(cfg_ready_o), 1);
        cyc();
        cfg_valid_i = 1'b0;
        chk("chg_ready_pend", 32'(cfg_ready_o), 0);
        chk("chg_ratio_old", 32'(ratio_o), 3);
        chk_seq("chg", 5, 32'b00001, 32'b00000);
        chk("chg_ratio_still", 32'(ratio_o), 3);
        chk("chg_ready_still", 32'(cfg_ready_o), 0);
        cyc();
        chk("chg_rise_clk", 32'(clk_r_o), 1);
        chk("chg_rise_tick", 32'(tick_o), 1);
        chk("chg_rise_ratio", 32'(ratio_o), 1);
        chk("chg_rise_ready", 32'(cfg_ready_o), 1);
        chk_seq("r1", 4, 32'b1001, 32'b1000);

        // switch to R=2, then disable in high phase
        cfg_valid_i = 1'b1; cfg_ratio_i = 8'd2;
        cyc();
        cfg_valid_i = 1'b0;
        chk("r2_pend_clk", 32'(clk_r_o), 1);
        chk("r2_pend_ratio", 32'(ratio_o), 1);
        chk_seq("r2a", 3, 32'b100, 32'b100);
        chk("r2_ratio", 32'(ratio_o), 2);
        cyc();
        chk("r2_high2", 32'(clk_r_o), 1);
        en_i = 1'b0;
        chk_seq("r2off", 5, 32'b00001, 32'b00000);
        chk("r2off_busy", 32'(busy_o), 0);
        chk_seq("r2idle", 2, 32'b00, 32'b00);

        // asynchronous reset mid high phase with a ratio pending
        en_i = 1'b1;
        cyc();
        cfg_valid_i = 1'b1; cfg_ratio_i = 8'd7;
        cyc();
        cfg_valid_i = 1'b0;
        chk("pre_rst_clk", 32'(clk_r_o), 1);
        chk("pre_rst_ready", 32'(cfg_ready_o), 0);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_clk", 32'(clk_r_o), 0);
        chk("arst_ratio", 32'(ratio_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_ready", 32'(cfg_ready_o), 0);
        en_i = 1'b0;
        cyc(); cyc();
        reset_i = 1'b0;
        cyc();
        chk("post_rst_busy", 32'(busy_o), 0);
        chk("post_rst_ready", 32'(cfg_ready_o), 1);
        en_i = 1'b1;
        chk_seq("rerun", 4, 32'b0101, 32'b0101);
        chk("rerun_ratio", 32'(ratio_o), 0);
        en_i = 1'b0;
        cyc(); cyc();
        chk("rerun_idle", 32'(busy_o), 0);

        // maximum ratio 255: period 512
        cfg_valid_i = 1'b1; cfg_ratio_i = 8'd255;
        cyc();
        cfg_valid_i = 1'b0;
        chk("max_ratio", 32'(ratio_o), 255);
        en_i = 1'b1;
        ticks = 0; first_tick = 0; second_tick = 0; highs = 0;
        for (int i = 1; i <= 1030; i++) begin
            cyc();
            if (tick_o) begin
                ticks++;
                if (ticks == 1) first_tick = i;
                if (ticks == 2) second_tick = i;
            end
            if (i <= 512 && clk_r_o) highs++;
            if (i == 512) chk("max_clk512", 32'(clk_r_o), 0);
            if (i == 513) chk("max_clk513", 32'(clk_r_o), 1);
        end
        chk("max_ticks", 32'(ticks), 3);
        chk("max_first", 32'(first_tick), 1);
        chk("max_period", 32'(second_tick - first_tick), 512);
        chk("max_high", 32'(highs), 256);
        en_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
